multi_digit_calc_core: RTL and testbench



---
 rtl/calc_pkg.sv | 32 +++
 rtl/bin2bcd_seq.sv | 60 ++++++
 rtl/multi_digit_calc_core.sv | 165 ++++++++++++++++
 tb/tb_multi_digit_calc_core.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the multi-digit calculator core: key codes,
// FSM state encoding, operator encoding and a key-to-operator helper.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_EQ  = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;

  typedef enum logic [1:0] {
    S_LEFT  = 2'd0,
    S_RIGHT = 2'd1,
    S_CONV  = 2'd2,
    S_ANS   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  function automatic op_t key_to_op(input logic [3:0] k);
    case (k)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle).
// Ports:
//   clk   - clock
//   rst   - synchronous clear, active high
//   start - load bin and begin an RW-cycle conversion
//   bin   - RW-bit unsigned binary input
//   bcd   - ND packed BCD digits, LSD in [3:0]; final once busy drops
//   busy  - high for the RW cycles following start
//   done  - high during the final conversion cycle, so a consumer can
//           act on the same edge that completes the last shift
module bin2bcd_seq #(
  parameter int RW = 14,
  parameter int ND = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [RW-1:0]   bin,
  output logic [4*ND-1:0] bcd,
  output logic            busy,
  output logic            done
);

  localparam int CNTW = $clog2(RW + 1);

  logic [RW-1:0]   shift_r;
  logic [4*ND-1:0] bcd_r;
  logic [4*ND-1:0] adj;
  logic [CNTW-1:0] cnt;

  // Every digit >= 5 gets +3 before the shift so it carries correctly.
  always_comb begin
    adj = bcd_r;
    for (int i = 0; i < ND; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= '0;
      bcd_r   <= '0;
      cnt     <= '0;
    end else if (start) begin
      shift_r <= bin;
      bcd_r   <= '0;
      cnt     <= CNTW'(RW);
    end else if (cnt != '0) begin
      bcd_r   <= {adj[4*ND-2:0], shift_r[RW-1]};
      shift_r <= shift_r << 1;
      cnt     <= cnt - 1'b1;
    end
  end

  assign bcd  = bcd_r;
  assign busy = (cnt != '0);
  assign done = (cnt == CNTW'(1));

endmodule

// File: rtl/multi_digit_calc_core.sv
// Calculator core: accumulates two decimal operands from keypad codes,
// computes add / |sub| / mult and hands the binary result to a sequential
// BCD converter for a sign-magnitude display answer.
//
// state   | meaning
// S_LEFT  | entering left operand
// S_RIGHT | operator latched, entering right operand
// S_CONV  | result converting to BCD, keys except clear ignored
// S_ANS   | answer on display, a digit starts a new calculation
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   key, key_valid    - key code (0-9 digit, 10 add, 11 sub, 12 mult,
//                       13 equal, 14 clear) and its one-cycle strobe
//   disp_bcd, disp_neg- 2*DIGITS BCD digits (LSD in [3:0]) and sign
//   op, state         - latched operator, current FSM state
//   busy, done        - converting, one-cycle answer-valid pulse
module multi_digit_calc_core
  import calc_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int OW     = $clog2(10**DIGITS),
  parameter int RW     = 2*OW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          key,
  input  logic                key_valid,
  output logic [8*DIGITS-1:0] disp_bcd,
  output logic                disp_neg,
  output logic [1:0]          op,
  output logic [2:0]          state,
  output logic                busy,
  output logic                done
);

  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  state_t        cur_state;
  op_t           op_r;
  logic [OW-1:0] left_bin, right_bin;
  logic [BW-1:0] left_bcd, right_bcd;
  logic [CW-1:0] left_cnt, right_cnt;
  logic          neg_r;
  logic          done_r;

  logic          clr_hit, is_digit, is_op;
  logic          conv_start, conv_rst, conv_busy, conv_done;
  logic [RW-1:0] result;
  logic [8*DIGITS-1:0] ans_bcd;

  assign clr_hit    = key_valid && (key == KEY_CLR);
  assign is_digit   = (key <= 4'd9);
  assign is_op      = (key >= KEY_ADD) && (key <= KEY_MUL);
  // The converter loads the combinational result on the same edge the
  // FSM enters S_CONV, so busy is high from the very next cycle.
  assign conv_start = !rst && key_valid && (cur_state == S_RIGHT) && (key == KEY_EQ);
  assign conv_rst   = rst || clr_hit;

  always_comb begin
    result = '0;
    case (op_r)
      OP_ADD:  result = RW'(left_bin) + RW'(right_bin);
      OP_SUB:  result = (left_bin >= right_bin) ? RW'(left_bin - right_bin)
                                                : RW'(right_bin - left_bin);
      OP_MUL:  result = RW'(left_bin) * RW'(right_bin);
      default: result = '0;
    endcase
  end

  bin2bcd_seq #(
    .RW (RW),
    .ND (2*DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (conv_rst),
    .start (conv_start),
    .bin   (result),
    .bcd   (ans_bcd),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  always_ff @(posedge clk) begin
    done_r <= 1'b0;
    if (rst || clr_hit) begin
      cur_state <= S_LEFT;
      op_r      <= OP_ADD;
      left_bin  <= '0;
      right_bin <= '0;
      left_bcd  <= '0;
      right_bcd <= '0;
      left_cnt  <= '0;
      right_cnt <= '0;
      neg_r     <= 1'b0;
    end else if (cur_state == S_CONV) begin
      if (conv_done) begin
        cur_state <= S_ANS;
        done_r    <= 1'b1;
      end
    end else if (key_valid) begin
      case (cur_state)
        S_LEFT: begin
          if (is_digit) begin
            if (left_cnt < CW'(DIGITS)) begin
              left_bin <= left_bin * OW'(10) + OW'(key);
              left_bcd <= (left_bcd << 4) | BW'(key);
              left_cnt <= left_cnt + 1'b1;
            end
          end else if (is_op) begin
            op_r      <= key_to_op(key);
            right_bin <= '0;
            right_bcd <= '0;
            right_cnt <= '0;
            cur_state <= S_RIGHT;
          end
        end
        S_RIGHT: begin
          if (is_digit) begin
            if (right_cnt < CW'(DIGITS)) begin
              right_bin <= right_bin * OW'(10) + OW'(key);
              right_bcd <= (right_bcd << 4) | BW'(key);
              right_cnt <= right_cnt + 1'b1;
            end
          end else if (is_op) begin
            if (right_cnt == '0)
              op_r <= key_to_op(key);
          end else if (key == KEY_EQ) begin
            neg_r     <= (op_r == OP_SUB) && (left_bin < right_bin);
            cur_state <= S_CONV;
          end
        end
        S_ANS: begin
          if (is_digit) begin
            left_bin  <= OW'(key);
            left_bcd  <= BW'(key);
            left_cnt  <= CW'(1);
            right_bin <= '0;
            right_bcd <= '0;
            right_cnt <= '0;
            neg_r     <= 1'b0;
            cur_state <= S_LEFT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (cur_state)
      S_LEFT:  disp_bcd = {{BW{1'b0}}, left_bcd};
      S_ANS:   disp_bcd = ans_bcd;
      default: disp_bcd = {{BW{1'b0}}, right_bcd};
    endcase
  end

  assign disp_neg = (cur_state == S_ANS) && neg_r;
  assign op       = op_r;
  assign state    = {1'b0, cur_state};
  assign busy     = conv_busy;
  assign done     = done_r;

endmodule

// File: tb/tb_multi_digit_calc_core.sv
module tb_multi_digit_calc_core;

  localparam int DIGITS = 2;
  localparam int RW     = 14;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          key;
  logic                key_valid;
  logic [8*DIGITS-1:0] disp_bcd;
  logic                disp_neg;
  logic [1:0]          op;
  logic [2:0]          state;
  logic                busy;
  logic                done;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  multi_digit_calc_core #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_valid (key_valid),
    .disp_bcd  (disp_bcd),
    .disp_neg  (disp_neg),
    .op        (op),
    .state     (state),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Key-level reference model: operands as plain integers, modes 0..3 as
  // named by the block description (left, right, converting, answer).
  int m_mode = 0, m_left = 0, m_right = 0, m_lcnt = 0, m_rcnt = 0;
  int m_op = 0, m_ans = 0, m_wait = 0;
  bit m_neg = 1'b0, m_done = 1'b0;

  function automatic logic [8*DIGITS-1:0] to_bcd(input int v);
    logic [8*DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 2*DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst || (key_valid && key == 4'd14)) begin
      m_mode = 0; m_left = 0; m_right = 0; m_lcnt = 0; m_rcnt = 0;
      m_op = 0; m_ans = 0; m_neg = 1'b0; m_wait = 0;
    end else if (m_mode == 2) begin
      m_wait--;
      if (m_wait == 0) begin m_mode = 3; m_done = 1'b1; end
    end else if (key_valid) begin
      if (key <= 4'd9) begin
        if (m_mode == 0 && m_lcnt < DIGITS) begin
          m_left = m_left*10 + int'(key); m_lcnt++;
        end else if (m_mode == 1 && m_rcnt < DIGITS) begin
          m_right = m_right*10 + int'(key); m_rcnt++;
        end else if (m_mode == 3) begin
          m_left = int'(key); m_lcnt = 1; m_right = 0; m_rcnt = 0;
          m_neg = 1'b0; m_mode = 0;
        end
      end else if (key >= 4'd10 && key <= 4'd12) begin
        if (m_mode == 0) begin
          m_op = int'(key) - 10; m_right = 0; m_rcnt = 0; m_mode = 1;
        end else if (m_mode == 1 && m_rcnt == 0) begin
          m_op = int'(key) - 10;
        end
      end else if (key == 4'd13 && m_mode == 1) begin
        case (m_op)
          0: m_ans = m_left + m_right;
          1: m_ans = (m_left >= m_right) ? m_left - m_right : m_right - m_left;
          default: m_ans = m_left * m_right;
        endcase
        m_neg  = (m_op == 1) && (m_left < m_right);
        m_wait = RW;
        m_mode = 2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [8*DIGITS-1:0] e_disp;
      case (m_mode)
        0:       e_disp = to_bcd(m_left);
        3:       e_disp = to_bcd(m_ans);
        default: e_disp = to_bcd(m_right);
      endcase
      chk("cyc_state", 32'(state), 32'(m_mode));
      chk("cyc_disp", 32'(disp_bcd), 32'(e_disp));
      chk("cyc_neg", 32'(disp_neg), 32'((m_mode == 3) && m_neg));
      chk("cyc_op", 32'(op), 32'(m_op));
      chk("cyc_busy", 32'(busy), 32'(m_mode == 2));
      chk("cyc_done", 32'(done), 32'(m_done));
    end
  end

  task automatic press(input logic [3:0] k);
    key = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      bad++; total++;
      $display("FAIL done_timeout got=0 want=1 at t=%0t", $time);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int nbusy, dcyc, ndone;
    rst = 1'b1; key = 4'd0; key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_disp", 32'(disp_bcd), 32'd0);

    // 47 + 58 with latency measurement
    press(4); press(7); press(10); press(5); press(8); press(13);
    nbusy = 0; dcyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done && dcyc == 0) dcyc = i;
    end
    chk("add_busy_cycles", 32'(nbusy), 32'd14);
    chk("add_done_cycle", 32'(dcyc), 32'd15);
    chk("add_bcd", 32'(disp_bcd), 32'h0105);
    chk("add_neg", 32'(disp_neg), 32'd0);

    press(1); press(2); press(11); press(9); press(9); press(13);
    wait_done();
    chk("sub_neg_bcd", 32'(disp_bcd), 32'h0087);
    chk("sub_neg_sign", 32'(disp_neg), 32'd1);

    press(9); press(9); press(11); press(9); press(9); press(13);
    wait_done();
    chk("sub_zero_bcd", 32'(disp_bcd), 32'h0000);
    chk("sub_zero_sign", 32'(disp_neg), 32'd0);

    press(9); press(9); press(12); press(9); press(9); press(13);
    wait_done();
    chk("mul_bcd", 32'(disp_bcd), 32'h9801);
    press(3);
    @(negedge clk);
    chk("newcalc_state", 32'(state), 32'd0);
    chk("newcalc_disp", 32'(disp_bcd), 32'h0003);
    chk("newcalc_neg", 32'(disp_neg), 32'd0);

    // digit overflow, '=' in S_LEFT, operator replacement
    press(14); press(1); press(2); press(3);
    @(negedge clk);
    chk("ovf_disp", 32'(disp_bcd), 32'h0012);
    press(13);
    @(negedge clk);
    chk("eq_left_state", 32'(state), 32'd0);
    press(5); press(10); press(11);
    @(negedge clk);
    chk("op_replace", 32'(op), 32'd1);
    press(3); press(13);
    wait_done();
    chk("ovf_sub_bcd", 32'(disp_bcd), 32'h0009);

    press(14); press(5); press(10); press(11); press(3); press(13);
    wait_done();
    chk("plain_sub_bcd", 32'(disp_bcd), 32'h0002);

    // keys while busy are ignored
    press(2); press(10); press(3); press(13);
    press(9); press(10); press(13);
    wait_done();
    chk("busy_ignore_bcd", 32'(disp_bcd), 32'h0005);

    // clear in busy cycle 5
    press(1); press(10); press(2); press(13);
    repeat (4) begin @(posedge clk); #1; end
    press(14);
    @(negedge clk);
    chk("clr_conv_state", 32'(state), 32'd0);
    chk("clr_conv_disp", 32'(disp_bcd), 32'd0);
    chk("clr_conv_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("clr_conv_nodone", 32'(ndone), 32'd0);

    // reset mid-entry
    press(4); press(10); press(6);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_state", 32'(state), 32'd0);
    chk("rst_mid_disp", 32'(disp_bcd), 32'd0);
    chk("rst_mid_op", 32'(op), 32'd0);
    press(2); press(12); press(3); press(13);
    wait_done();
    chk("rst_mid_mul", 32'(disp_bcd), 32'h0006);

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      int r, kr;
      r  = $urandom_range(0, 99);
      kr = $urandom_range(0, 99);
      rst       = (r == 0);
      key_valid = (r < 60);
      if (kr < 55)      key = 4'($urandom_range(0, 9));
      else if (kr < 70) key = 4'($urandom_range(10, 12));
      else if (kr < 85) key = 4'd13;
      else if (kr < 88) key = 4'd14;
      else if (kr < 90) key = 4'd15;
      else              key = 4'($urandom_range(0, 9));
      @(posedge clk); #1;
    end
    rst = 1'b0; key_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
